// File: rtl/alarm_mode_controller.sv
// ---------------------------------------------------------------------------
// alarm_mode_controller
//   Mode/sequencing FSM of the alarm clock. It edge-detects keypad digits,
//   assembles a 4-digit HH:MM entry in key_buffer, abandons stale entries
//   after TIMEOUT_SEC seconds of inactivity, and issues one-cycle load
//   strobes for the current-time counter and the alarm register. It also
//   drives the display-mux selects.
//
// Ports
//   clock         in   1   system clock, rising edge
//   reset         in   1   asynchronous, active-high
//   one_second    in   1   single-cycle one-second tick
//   key           in   4   keypad code: 0-9 digit, anything above 9 = no key
//   alarm_button  in   1   level: set alarm (entry) / show alarm (idle)
//   time_button   in   1   level: set current time (entry)
//   key_buffer    out  16  {ms_hr, ls_hr, ms_min, ls_min}
//   load_new_c    out  1   strobe: load key_buffer into current-time counter
//   load_new_a    out  1   strobe: load key_buffer into alarm register
//   show_a        out  1   display shows the alarm time
//   show_new_time out  1   display shows key_buffer
//   entry_error   out  1   strobe: entry rejected as out of range
// ---------------------------------------------------------------------------
module alarm_mode_controller #(
   parameter int unsigned TIMEOUT_SEC = 10,
   parameter logic [3:0]  NOKEY       = 4'd10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        one_second,
   input  logic [3:0]  key,
   input  logic        alarm_button,
   input  logic        time_button,
   output logic [15:0] key_buffer,
   output logic        load_new_c,
   output logic        load_new_a,
   output logic        show_a,
   output logic        show_new_time,
   output logic        entry_error
);

   localparam int unsigned      CNT_W   = $clog2(TIMEOUT_SEC + 1);
   localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_SEC);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_SEC - 1);

   typedef enum logic [2:0] {
      SHOW_TIME  = 3'd0,
      KEY_STORED = 3'd1,
      KEY_WAITED = 3'd2,
      KEY_ENTRY  = 3'd3,
      SET_ALARM  = 3'd4,
      SET_TIME   = 3'd5,
      SHOW_ALARM = 3'd6
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       key_p1;
   logic             vld_p0, vld_p1;
   logic             key_event;
   logic             timeout_hit;
   logic [CNT_W-1:0] timeout_cnt;
   logic             buffer_ok;

   // HH:MM range check; 24:00 and above are rejected.
   function automatic logic entry_in_range(input logic [15:0] b);
      logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
      ms_hr  = b[15:12];
      ls_hr  = b[11:8];
      ms_min = b[7:4];
      ls_min = b[3:0];
      entry_in_range = (ms_hr <= 4'd2) &&
                       (ls_hr <= ((ms_hr == 4'd2) ? 4'd3 : 4'd9)) &&
                       (ms_min <= 4'd5) &&
                       (ls_min <= 4'd9);
   endfunction

   // p0: raw keypad code; p1: previous-cycle sample. The p1 sample also
   // carries the accepted digit into the KEY_STORED cycle, so a digit
   // pressed for a single cycle is still shifted in correctly.
   assign vld_p0    = (key <= 4'd9);
   assign vld_p1    = (key_p1 <= 4'd9);
   assign key_event = vld_p0 && !vld_p1;

   // >= rather than == so a tick that lands while the counter has already
   // reached its limit (release and timeout in the same cycle) still expires.
   assign timeout_hit = one_second && (timeout_cnt >= TO_LAST);

   assign buffer_ok = entry_in_range(key_buffer);

   always_comb begin
      state_nxt     = state;
      load_new_c    = 1'b0;
      load_new_a    = 1'b0;
      entry_error   = 1'b0;
      show_a        = 1'b0;
      show_new_time = 1'b0;
      case (state)
         SHOW_TIME: begin
            if (alarm_button)   state_nxt = SHOW_ALARM;
            else if (key_event) state_nxt = KEY_STORED;
         end
         KEY_STORED: begin
            show_new_time = 1'b1;
            state_nxt     = KEY_WAITED;
         end
         KEY_WAITED: begin
            show_new_time = 1'b1;
            if (!vld_p0)          state_nxt = KEY_ENTRY;
            else if (timeout_hit) state_nxt = SHOW_TIME;
         end
         KEY_ENTRY: begin
            show_new_time = 1'b1;
            if (alarm_button)     state_nxt = SET_ALARM;
            else if (time_button) state_nxt = SET_TIME;
            else if (key_event)   state_nxt = KEY_STORED;
            else if (timeout_hit) state_nxt = SHOW_TIME;
         end
         SET_ALARM: begin
            show_new_time = 1'b1;
            load_new_a    = buffer_ok;
            entry_error   = !buffer_ok;
            state_nxt     = SHOW_TIME;
         end
         SET_TIME: begin
            show_new_time = 1'b1;
            load_new_c    = buffer_ok;
            entry_error   = !buffer_ok;
            state_nxt     = SHOW_TIME;
         end
         SHOW_ALARM: begin
            show_a = 1'b1;
            if (!alarm_button) state_nxt = SHOW_TIME;
         end
         default: state_nxt = SHOW_TIME;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= SHOW_TIME;
         key_p1      <= NOKEY;
         timeout_cnt <= '0;
         key_buffer  <= 16'h0000;
      end else begin
         state  <= state_nxt;
         key_p1 <= key;

         // The counter only runs while an entry is pending; every other
         // state (including KEY_STORED) holds it at zero.
         if ((state == KEY_WAITED) || (state == KEY_ENTRY)) begin
            if (one_second && (timeout_cnt < TO_MAX))
               timeout_cnt <= timeout_cnt + 1'b1;
         end else begin
            timeout_cnt <= '0;
         end

         // Any return to SHOW_TIME (commit, error, timeout) discards the entry.
         if (state_nxt == SHOW_TIME)
            key_buffer <= 16'h0000;
         else if (state == KEY_STORED)
            key_buffer <= {key_buffer[11:0], key_p1};
      end
   end

endmodule

// File: tb/tb_alarm_mode_controller.sv
module tb_alarm_mode_controller;

   localparam logic [3:0] NOKEY = 4'd10;
   localparam logic [1:0] K_C = 2'd0, K_A = 2'd1, K_E = 2'd2, K_X = 2'd3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        one_second = 1'b0;
   logic [3:0]  key = NOKEY;
   logic        alarm_button = 1'b0;
   logic        time_button = 1'b0;
   logic [15:0] key_buffer;
   logic        load_new_c, load_new_a, show_a, show_new_time, entry_error;

   int total = 0;
   int bad   = 0;
   logic [17:0] sb[$];

   alarm_mode_controller #(.TIMEOUT_SEC(10), .NOKEY(NOKEY)) dut (
      .clock(clock), .reset(reset), .one_second(one_second), .key(key),
      .alarm_button(alarm_button), .time_button(time_button),
      .key_buffer(key_buffer), .load_new_c(load_new_c), .load_new_a(load_new_a),
      .show_a(show_a), .show_new_time(show_new_time), .entry_error(entry_error)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every strobe must match the oldest expected entry.
   always @(negedge clock) begin
      logic [1:0]  kind;
      logic [17:0] exp;
      if (!reset && (load_new_c || load_new_a || entry_error)) begin
         case ({load_new_a, load_new_c, entry_error})
            3'b100:  kind = K_A;
            3'b010:  kind = K_C;
            3'b001:  kind = K_E;
            default: kind = K_X;
         endcase
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe: got kind=%0d buf=%h expected none", kind, key_buffer);
         end else begin
            exp = sb.pop_front();
            if ({kind, key_buffer} !== exp) begin
               bad++;
               $display("FAIL strobe: got kind=%0d buf=%h expected kind=%0d buf=%h",
                        kind, key_buffer, exp[17:16], exp[15:0]);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic press(input logic [3:0] d);
      key = d;
      cyc(3);
      key = NOKEY;
      cyc(1);
   endtask

   task automatic tick();
      one_second = 1'b1;
      cyc(1);
      one_second = 1'b0;
      cyc(1);
   endtask

   task automatic btn(input logic a, input logic t);
      alarm_button = a;
      time_button  = t;
      cyc(1);
      alarm_button = 1'b0;
      time_button  = 1'b0;
      cyc(2);
   endtask

   task automatic enter4(input logic [15:0] d);
      press(d[15:12]);
      press(d[11:8]);
      press(d[7:4]);
      press(d[3:0]);
   endtask

   initial begin
      int hi_cnt;
      cyc(2);
      chk("reset_buffer", 32'(key_buffer), 32'h0);
      chk("reset_outputs", 32'({load_new_c, load_new_a, entry_error, show_a, show_new_time}), 32'h0);
      reset = 1'b0;
      cyc(2);

      // 1) set time 11:23
      enter4(16'h1123);
      chk("t1_buffer", 32'(key_buffer), 32'h1123);
      chk("t1_entry_display", 32'(show_new_time), 32'h1);
      sb.push_back({K_C, 16'h1123});
      btn(1'b0, 1'b1);
      chk("t1_buffer_cleared", 32'(key_buffer), 32'h0);
      chk("t1_idle_display", 32'(show_new_time), 32'h0);

      // 2) set alarm 11:30, then both buttons together
      enter4(16'h1130);
      sb.push_back({K_A, 16'h1130});
      btn(1'b1, 1'b0);
      enter4(16'h1130);
      sb.push_back({K_A, 16'h1130});
      btn(1'b1, 1'b1);
      chk("t2_buffer_cleared", 32'(key_buffer), 32'h0);

      // 3) timeout, then key event coincident with the expiring tick
      press(4'd1);
      repeat (9) tick();
      chk("t3_before_timeout", 32'(show_new_time), 32'h1);
      tick();
      chk("t3_timeout_display", 32'(show_new_time), 32'h0);
      chk("t3_timeout_buffer", 32'(key_buffer), 32'h0);
      press(4'd1);
      repeat (9) tick();
      one_second = 1'b1;
      key = 4'd5;
      cyc(1);
      one_second = 1'b0;
      cyc(2);
      key = NOKEY;
      cyc(1);
      chk("t3_key_beats_tick", 32'(key_buffer), 32'h0015);
      repeat (9) tick();
      chk("t3_counter_restarted", 32'(show_new_time), 32'h1);
      press(4'd0);
      press(4'd0);
      sb.push_back({K_C, 16'h1500});
      btn(1'b0, 1'b1);

      // 4) out-of-range and boundary entries
      enter4(16'h2400);
      sb.push_back({K_E, 16'h2400});
      btn(1'b0, 1'b1);
      enter4(16'h2359);
      sb.push_back({K_C, 16'h2359});
      btn(1'b0, 1'b1);
      press(4'd7);
      press(4'd5);
      chk("t4_short_entry", 32'(key_buffer), 32'h0075);
      sb.push_back({K_E, 16'h0075});
      btn(1'b0, 1'b1);
      press(4'd9);
      enter4(16'h1234);
      chk("t4_long_entry", 32'(key_buffer), 32'h1234);
      sb.push_back({K_A, 16'h1234});
      btn(1'b1, 1'b0);

      // 5) show alarm while the button is held
      hi_cnt = 0;
      alarm_button = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         if (show_a) hi_cnt++;
      end
      alarm_button = 1'b0;
      cyc(1);
      chk("t5_show_a_cycles", 32'(hi_cnt), 32'd5);
      chk("t5_show_a_released", 32'(show_a), 32'h0);

      // 6) asynchronous reset in KEY_WAITED, then a long key hold
      key = 4'd3;
      cyc(2);
      chk("t6_in_waited", 32'(show_new_time), 32'h1);
      #3;
      reset = 1'b1;
      #1;
      chk("t6_async_display", 32'(show_new_time), 32'h0);
      chk("t6_async_buffer", 32'(key_buffer), 32'h0);
      key = NOKEY;
      cyc(2);
      reset = 1'b0;
      cyc(1);
      key = 4'd7;
      cyc(8);
      key = NOKEY;
      cyc(1);
      chk("t6_single_shift", 32'(key_buffer), 32'h0007);
      sb.push_back({K_C, 16'h0007});
      btn(1'b0, 1'b1);

      cyc(3);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
